// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide unit holding HI/LO.
// Operates on magnitudes and applies sign correction in a single FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] opnd;
    logic [2*WIDTH-1:0] acc;
    logic is_div, qsign, rsign;
    logic sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
    logic [WIDTH:0] mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;
    always_comb begin
        sa = op[0] & srca[WIDTH-1];
        sb = op[0] & srcb[WIDTH-1];
        mag_a = sa ? -srca : srca;
        mag_b = sb ? -srcb : srcb;
        // mul: acc = {partial sum, remaining multiplier bits}
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step = {mul_sum, acc[WIDTH-1:1]};
        // div: acc = {remainder, dividend/quotient}; bit WIDTH of diff is the borrow
        div_sh = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_sh - {1'b0, opnd};
        div_step = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod = qsign ? -acc : acc;
        quo = qsign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem = rsign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            cnt <= '0;
            opnd <= '0;
            acc <= '0;
            is_div <= 1'b0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cancel && start) begin
                        busy <= 1'b1;
                        is_div <= op[1];
                        cnt <= CW'(WIDTH);
                        if (op[1] && srcb == '0) begin
                            state <= FIX;
                            acc <= {srca, {WIDTH{1'b1}}};
                            qsign <= 1'b0;
                            rsign <= 1'b0;
                        end else begin
                            state <= op[1] ? DIV : MUL;
                            opnd <= op[1] ? mag_b : mag_a;
                            acc <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
                            qsign <= sa ^ sb;
                            rsign <= sa;
                        end
                    end else if (!cancel) begin
                        if (mthi) hi <= srca;
                        if (mtlo) lo <= srca;
                    end
                end
                MUL, DIV: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy <= 1'b0;
                    end else begin
                        acc <= state == DIV ? div_step : mul_step;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    if (!cancel) begin
                        done <= 1'b1;
                        {hi, lo} <= is_div ? {rem, quo} : prod;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: arithmetic reference model compared every cycle, plus directed literal checks.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0, cancel = 1'b0;
    logic [1:0] op = 2'b00;
    logic [31:0] srca = '0, srcb = '0;
    logic busy, done;
    logic [31:0] hi, lo;
    int n_cmp = 0, n_bad = 0;
    logic chk = 1'b0;
    int m_left = 0;
    logic m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .mthi(mthi), .mtlo(mtlo), .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        if (o[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
        x = o[0] ? longint'($signed(a)) : longint'({32'd0, a});
        y = o[0] ? longint'($signed(b)) : longint'({32'd0, b});
        if (!o[1]) return 64'(x * y);
        return {32'(x % y), 32'(x / y)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (cancel) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        {m_hi, m_lo} = m_res;
                        m_done = 1'b1;
                    end
                end
            end else if (!cancel) begin
                if (start) begin
                    m_res = calc(op, srca, srcb);
                    m_left = (op[1] && srcb == 32'd0) ? 1 : 33;
                end else begin
                    if (mthi) m_hi = srca;
                    if (mtlo) m_lo = srca;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("busy", 64'(busy), 64'(m_left != 0));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op = o;
        srca = a;
        srcb = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic await_done(input string nm, input int lat, input logic [31:0] ehi, input logic [31:0] elo);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 100);
        check({nm, "_lat"}, 64'(c), 64'(lat));
        check({nm, "_hi"}, 64'(hi), 64'(ehi));
        check({nm, "_lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;
        chk = 1'b1;
        @(negedge clk);

        launch(2'b00, 32'hFFFF_FFFF, 32'd2);
        await_done("multu", 33, 32'h0000_0001, 32'hFFFF_FFFE);
        launch(2'b01, 32'hFFFF_FFFD, 32'd5);
        await_done("mult_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        launch(2'b01, 32'h8000_0000, 32'h8000_0000);
        await_done("mult_min", 33, 32'h4000_0000, 32'h0000_0000);
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        await_done("div_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        launch(2'b10, 32'd100, 32'd7);
        await_done("divu", 33, 32'd2, 32'd14);
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        await_done("div_ovf", 33, 32'd0, 32'h8000_0000);
        launch(2'b10, 32'd7, 32'd0);
        await_done("div_zero", 1, 32'd7, 32'hFFFF_FFFF);

        mthi = 1'b1;
        srca = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        launch(2'b00, 32'h55, 32'h3);
        repeat (8) @(negedge clk);
        check("cancel_pre_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_hi", 64'(hi), 64'h1234);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("cancel_no_done", 64'(dones), 64'd0);

        launch(2'b00, 32'd3, 32'd4);
        mtlo = 1'b1;
        srca = 32'hDEAD;
        @(negedge clk);
        mtlo = 1'b0;
        await_done("mtlo_busy", 32, 32'd0, 32'd12);

        mtlo = 1'b1;
        launch(2'b00, 32'd5, 32'd6);
        mtlo = 1'b0;
        await_done("start_mtlo", 33, 32'd0, 32'd30);

        launch(2'b11, 32'hFFFF_FF9C, 32'd3);
        repeat (18) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        launch(2'b00, 32'd6, 32'd7);
        launch(2'b10, 32'd100, 32'd7);
        await_done("start_busy", 32, 32'd0, 32'd42);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
